// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of one functional-unit result per cycle onto a registered CDB.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif
module cdb_arbiter #(
  parameter int N_REQ = 4,
  parameter int ROB_W = `ROB_ENTRY_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*ROB_W-1:0] req_rob_idx,
  input  logic [N_REQ*32-1:0] req_value,
  output logic [N_REQ-1:0]   req_ready,
  output logic               cdb_valid,
  output logic [ROB_W-1:0]   cdb_rob_idx,
  output logic [31:0]        cdb_value,
  output logic [2:0]         cdb_src,
  output logic [CNT_W-1:0]   conflict_cnt
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] ptr, w, j;
  logic hit, multi;
  // Search from ptr upward with modulo wrap so non-power-of-two N_REQ rotates correctly.
  always_comb begin
    hit = 1'b0;
    w = '0;
    j = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = PW'((int'(ptr) + k) % N_REQ);
      if (!hit && !flush && req_valid[j]) begin
        hit = 1'b1;
        w = j;
      end
    end
    if (hit) req_ready[w] = 1'b1;
  end
  assign multi = !flush && ($countones(req_valid) > 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_value <= '0;
      cdb_src <= '0;
      conflict_cnt <= '0;
    end else begin
      cdb_valid <= hit;
      if (hit) begin
        ptr <= (w == PW'(N_REQ - 1)) ? '0 : w + 1'b1;
        cdb_rob_idx <= req_rob_idx[int'(w)*ROB_W +: ROB_W];
        cdb_value <= req_value[int'(w)*32 +: 32];
        cdb_src <= 3'(w);
      end
      if (multi && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single common data bus (CDB) among the out-of-order core's functional units. Each functional unit presents a completed result tagged with its ROB index. The arbiter grants at most one per cycle and broadcasts the winner on a registered CDB, which the ROB and reservation stations snoop. It sits between the execute stage and the ROB/RS writeback ports, and honours the same pipeline flush that clears the rename/dispatch stage registers.

## Interface
Parameters:
- N_REQ, 4, number of requesting functional units (ALU, MEM, BRA, MUL); legal range 2..8.
- ROB_W, `ROB_ENTRY_WIDTH, width of a ROB index.
- CNT_W, 16, width of the conflict performance counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  pipeline flush (mispredict/exception); synchronous, active-high.
- req_valid  in  N_REQ  requester i holds a completed result.
- req_rob_idx  in  N_REQ*ROB_W  packed ROB indices; slice i belongs to requester i.
- req_value  in  N_REQ*32  packed result values; slice i belongs to requester i.
- req_ready  out  N_REQ  one-hot or zero grant; combinational from inputs and state.
- cdb_valid  out  1  registered CDB broadcast valid.
- cdb_rob_idx  out  ROB_W  registered ROB index of the broadcast.
- cdb_value  out  32  registered value of the broadcast.
- cdb_src  out  3  registered index of the granted requester.
- conflict_cnt  out  CNT_W  saturating count of cycles in which more than one requester was valid.

## Operation
- State: round-robin pointer ptr (0..N_REQ-1), CDB output registers, conflict_cnt.
- Grant: search from ptr upward, wrapping modulo N_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
- No valid requests: req_ready=0. ptr is unchanged.
- flush=1: req_ready forced to 0. The cycle counts as no grant. ptr is unchanged.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. A requester must hold valid, index and value stable until it is granted. It may drop valid only under flush.
- After a grant to i: ptr <= (i+1) mod N_REQ. Non-power-of-two N_REQ wraps correctly: for N_REQ=3, ptr goes 2 -> 0.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- CDB register on a grant: cdb_valid<=1, cdb_rob_idx/cdb_value <= slice i, cdb_src <= i.
- CDB register on no grant: cdb_valid<=0. idx, value and src hold their previous values.
- conflict_cnt increments when popcount(req_valid) >= 2 and flush=0. It saturates at all-ones.

## Timing
- Reset (rst=0, asynchronous): cdb_valid=0, cdb_rob_idx=0, cdb_value=0, cdb_src=0, ptr=0, conflict_cnt=0.
- req_ready is valid in the same cycle as req_valid. Grant latency is zero.
- Broadcast latency is 1: a grant in cycle t gives cdb_valid=1 in cycle t+1 only, unless a new grant occurs in t+1. Back-to-back grants give a continuous cdb_valid.
- Throughput is one result per cycle.
- Flush in cycle t: no grant in t, so cdb_valid=0 in t+1. A broadcast already registered in t (granted in t-1) is still visible during t; the ROB discards it.
- Reset asserted mid-stream: the outputs clear immediately and any in-flight grant is lost. After rst deasserts, the first grant searches from requester 0.

## Test plan
- Reset: hold rst=0 with all req_valid=1, then release. Required: cdb_valid=0 and conflict_cnt=0 during reset. First cycle after release: req_ready=4'b0001, ptr=0.
- Single requester: req_valid=4'b0100, rob_idx=5, value=32'hDEAD_BEEF in cycle t. Required: req_ready=4'b0100 in t. In t+1: cdb_valid=1, cdb_rob_idx=5, cdb_value=32'hDEAD_BEEF, cdb_src=2. In t+2: cdb_valid=0.
- Rotation: all four valid continuously for 8 cycles. Required grant order 0,1,2,3,0,1,2,3. cdb_valid=1 every cycle from the second onward. conflict_cnt=8.
- Wrap and skip: ptr=3, req_valid=4'b0011. Required: grant 0, then ptr=1. If still 4'b0011, grant 1 next, then ptr=2.
- Flush: two requesters valid with flush=1 in cycle t. Required: req_ready=0 in t, cdb_valid=0 in t+1, ptr unchanged, conflict_cnt unchanged.
- Saturation: with CNT_W=4, run 20 conflicting cycles. Required: conflict_cnt=4'hF.
